// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
// Memory-stage responder between the EXE and MEM pipeline registers. A 32-bit
// load or store is served as two half-word accesses (low half, then high half)
// against an external asynchronous 16-bit SRAM. ready is held low to freeze the
// pipeline until the access completes.
//
// Handshake: the EXE side presents MEM_R_EN/MEM_W_EN with ALU_result/ST_val and
// keeps them stable while ready=0; the transfer is complete on the rising edge
// where ready=1 (IDLE with no request, or the single DONE cycle).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN  load / store request (store wins if both high)
//   ALU_result          byte address; ST_val store data
//   ready               1 = pipeline may advance, 0 = freeze
//   read_data           load result, valid while ready=1 in DONE
//   SRAM_ADDR           half-word address {word[16:0], half}
//   SRAM_DQ_out/_oe     write data and its output enable
//   SRAM_DQ_in          read data from SRAM
//   SRAM_WE_N           active-low write strobe
//   dbg_state           current FSM state (IDLE=0, LOW=1, HIGH=2, DONE=3)
//
// Optional feature macro: MEM_READ_BUFFER_EN adds a one-entry buffer of the
// last completed load so a repeated load of the same word finishes in IDLE.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  output logic        ready,
  output logic [31:0] read_data,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [29:0] word_q, word_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [31:0] read_data_q, read_data_d;

  logic        req;
  logic [31:0] offset;
  logic [29:0] req_word;
  logic        active;
  logic        last_cycle;
  logic        sig_unused;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign offset   = ALU_result - ADDR_BASE;
  assign req_word = offset[31:2];
  // Byte-lane bits are ignored; upper word bits only matter for buffer matching.
  assign sig_unused = &{1'b0, offset[1:0], word_q[29:17]};

`ifdef MEM_READ_BUFFER_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_word_q, buf_word_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_hit;

  assign buf_hit = MEM_R_EN && !MEM_W_EN && buf_valid_q && (buf_word_q == req_word);

  // Refresh the entry when an access finishes: a load replaces it, a store to
  // the buffered word keeps the data coherent, other stores leave it alone.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (state_q == DONE) begin
      if (!store_q) begin
        buf_valid_d = 1'b1;
        buf_word_d  = word_q;
        buf_data_d  = read_data_q;
      end else if (buf_valid_q && (buf_word_q == word_q)) begin
        buf_data_d  = ST_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign last_cycle = (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    word_d      = word_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
`ifdef MEM_READ_BUFFER_EN
          if (buf_hit) begin
            ready       = 1'b1;
            read_data_d = buf_data_q;
          end else
`endif
          begin
            state_d = LOW;
            cnt_d   = '0;
            store_d = MEM_W_EN;
            word_d  = req_word;
            addr_d  = {req_word[16:0], 1'b0};
            if (MEM_W_EN) dq_out_d = ST_val[15:0];
          end
        end
      end
      LOW: begin
        if (last_cycle) begin
          if (!store_q) read_data_d[15:0] = SRAM_DQ_in;
          state_d = HIGH;
          cnt_d   = '0;
          addr_d  = {word_q[16:0], 1'b1};
          if (store_q) dq_out_d = ST_val[31:16];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          if (!store_q) read_data_d[31:16] = SRAM_DQ_in;
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      word_q      <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      read_data_q <= read_data_d;
    end
  end

  // SRAM strobes decode only registered state; the last cycle of each phase
  // releases WE_N so address and data are held past the write edge.
  assign active      = (state_q == LOW) || (state_q == HIGH);
  assign SRAM_DQ_oe  = store_q && active;
  assign SRAM_WE_N   = ~(store_q && active && !last_cycle);
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = dq_out_q;
  assign read_data   = read_data_q;
  assign dbg_state   = state_q;

endmodule
